fpu_normalize: RTL and testbench
================================

Name: fpu_normalize

Overview:
- Post-add normalization stage of the single-precision FPU datapath; sits directly upstream of the rounding stage.
- Takes the raw 28-bit significand from the add/sub unit, together with its biased exponent, sign and effective-operation bit.
- Produces the 25-bit normalized significand (hidden+fraction+G) and sticky T that rounding consumes, plus the adjusted exponent and pre-round flags.
- Two-stage, free-running, non-stalling pipeline with valid tagging.

Parameters:
- MW, 28, raw significand width {carry, hidden, frac[22:0], G, R, S}
- EW, 8, biased exponent width
- EMAX, 255, all-ones exponent (overflow threshold)

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- Mraw  in  28  raw significand: [27]=carry, [26]=hidden, [25:3]=frac, [2]=G, [1]=R, [0]=S
- Ez_in  in  8  biased exponent of Mraw (0 = denormal operands)
- Sz_in  in  1  result sign from adder
- eff_sub  in  1  1 = effective subtraction
- R_mode_ext  in  2  rounding mode: 00 near, 01 zero, 10 +inf, 11 -inf
- out_valid  out  1  output beat valid
- After_norm  out  25  normalized {hidden, frac[22:0], G}
- T  out  1  sticky (OR of all bits below G)
- Sz  out  1  result sign
- Ez_norm  out  8  adjusted biased exponent
- ovf_pre  out  1  exponent reached EMAX
- denorm  out  1  result is subnormal (hidden bit 0, nonzero)
- zero  out  1  exact zero result

Behaviour:
- Reset: every pipeline register and every output is 0, asynchronously.
- Latency: exactly 2 cycles from in_valid to out_valid. Throughput 1 beat per cycle; no backpressure.
- Register stages advance every cycle. out_valid is in_valid delayed by 2. Data registers load unconditionally.
- Stage 1 (first rising edge) registers:
  - Mraw, Ez_in, Sz_in, eff_sub, R_mode_ext.
  - carry = Mraw[27].
  - iszero = (Mraw == 0).
  - lzc = count of leading zeros of Mraw[26:0], range 0..27.
- Stage 2 computes sh and the 27-bit shifted value S27, then registers outputs:
  - carry=1: S27 = {Mraw[27:2], Mraw[1]|Mraw[0]} (right shift by 1, sticky preserved). Ez_norm = Ez+1.
  - carry=0, iszero=0:
    - sh = lzc if Ez > lzc.
    - otherwise sh = Ez-1 when Ez≥1.
    - sh = 0 when Ez=0.
    - S27 = Mraw[26:0] << sh, zero fill. Ez_norm = Ez - sh.
  - If S27[26]=0 after the limited shift: denorm=1 and Ez_norm forced to 0.
  - iszero=1: After_norm=0, T=0, Ez_norm=0, zero=1, denorm=0.
  - After_norm = S27[26:2]. T = S27[1] | S27[0].
- Exponent arithmetic: 9-bit internal, so no wrap. ovf_pre=1 when the carry case gives Ez_norm = 255. Ez_norm stays 8 bits (255 ≤ 2^8-1).
- Sign:
  - Sz = Sz_in, except on exact zero from eff_sub=1.
  - In that case Sz = (R_mode==2'b11): -0 only in round-to-−inf, otherwise +0.
  - Exact zero from eff_sub=0 keeps Sz_in.
- Flags are mutually exclusive: at most one of ovf_pre, denorm, zero per beat.
- Beats with in_valid=0 still propagate data; consumers qualify with out_valid.
- Reset asserted mid-stream clears all in-flight beats. out_valid stays 0 until 2 edges after the first valid beat following release.

Test Plan:
- Carry case: Mraw=28'h8000000, Ez_in=127, Sz_in=0 -> after 2 cycles After_norm=25'h1000000, T=0, Ez_norm=128, flags 0.
- Already normalized with sticky: Mraw=28'h4000003, Ez_in=100 -> After_norm=25'h1000000, T=1, Ez_norm=100.
- Cancellation: Mraw=28'h0000100, Ez_in=100 -> sh=18, After_norm=25'h1000000, T=0, Ez_norm=82.
- Denormal limit: Mraw=28'h0000100, Ez_in=10 -> sh=9, After_norm=25'h0008000, Ez_norm=0, denorm=1.
- Exact zero: Mraw=0, eff_sub=1, R_mode_ext=11 -> zero=1, Sz=1, Ez_norm=0. Repeat with R_mode_ext=00 -> Sz=0.
- Overflow plus streaming/reset:
  - Mraw=28'h8000000, Ez_in=254 -> Ez_norm=255, ovf_pre=1.
  - Back-to-back 5 beats -> 5 consecutive out_valid cycles, in order.
  - Pull RST low with 2 beats in flight -> outputs 0 immediately, no stale out_valid after release.

Source files
------------

// File: rtl/fpu_normalize.sv
// Post-add normalization stage: turns the raw adder significand into the
// hidden+fraction+G form and sticky bit that the rounding stage expects.
module fpu_normalize #(
    parameter int MW   = 28,
    parameter int EW   = 8,
    parameter int EMAX = 255
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    input  logic [MW-1:0] Mraw,
    input  logic [EW-1:0] Ez_in,
    input  logic          Sz_in,
    input  logic          eff_sub,
    input  logic [1:0]    R_mode_ext,
    output logic          out_valid,
    output logic [24:0]   After_norm,
    output logic          T,
    output logic          Sz,
    output logic [EW-1:0] Ez_norm,
    output logic          ovf_pre,
    output logic          denorm,
    output logic          zero
);

    logic          s1_valid;
    logic [MW-1:0] s1_mraw;
    logic [EW-1:0] s1_ez;
    logic          s1_sz;
    logic          s1_sub;
    logic [1:0]    s1_rm;
    logic          s1_carry;
    logic          s1_iszero;
    logic [4:0]    s1_lzc;

    logic [4:0]    lzc_in;
    logic [4:0]    sh;
    logic [26:0]   s27;
    logic [EW:0]   ez9;
    logic          sz_n;
    logic          ovf_n;
    logic          den_n;
    logic          zero_n;

    // Leading-zero count of Mraw[26:0]; the highest set bit wins, 27 when empty.
    always_comb begin
        lzc_in = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (Mraw[i]) lzc_in = 5'(26 - i);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid  <= 1'b0;
            s1_mraw   <= '0;
            s1_ez     <= '0;
            s1_sz     <= 1'b0;
            s1_sub    <= 1'b0;
            s1_rm     <= 2'b00;
            s1_carry  <= 1'b0;
            s1_iszero <= 1'b0;
            s1_lzc    <= 5'd0;
        end else begin
            s1_valid  <= in_valid;
            s1_mraw   <= Mraw;
            s1_ez     <= Ez_in;
            s1_sz     <= Sz_in;
            s1_sub    <= eff_sub;
            s1_rm     <= R_mode_ext;
            s1_carry  <= Mraw[MW-1];
            s1_iszero <= (Mraw == '0);
            s1_lzc    <= lzc_in;
        end
    end

    // The left shift is capped so the exponent never drops below 1; anything
    // still unnormalized after the capped shift is a subnormal with exponent 0.
    always_comb begin
        sh     = 5'd0;
        s27    = '0;
        ez9    = '0;
        sz_n   = s1_sz;
        ovf_n  = 1'b0;
        den_n  = 1'b0;
        zero_n = 1'b0;
        if (s1_iszero) begin
            zero_n = 1'b1;
            if (s1_sub) sz_n = (s1_rm == 2'b11);
        end else if (s1_carry) begin
            s27 = {s1_mraw[27:2], s1_mraw[1] | s1_mraw[0]};
            ez9 = {1'b0, s1_ez} + 9'd1;
            if (ez9 >= 9'(EMAX)) begin
                ovf_n = 1'b1;
                ez9   = 9'(EMAX);
            end
        end else begin
            if (s1_ez > {3'b000, s1_lzc}) begin
                sh = s1_lzc;
            end else if (s1_ez != '0) begin
                sh = 5'(s1_ez - 8'd1);
            end
            s27 = s1_mraw[26:0] << sh;
            ez9 = {1'b0, s1_ez} - {4'b0000, sh};
            if (!s27[26]) begin
                den_n = 1'b1;
                ez9   = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid  <= 1'b0;
            After_norm <= '0;
            T          <= 1'b0;
            Sz         <= 1'b0;
            Ez_norm    <= '0;
            ovf_pre    <= 1'b0;
            denorm     <= 1'b0;
            zero       <= 1'b0;
        end else begin
            out_valid  <= s1_valid;
            After_norm <= s27[26:2];
            T          <= s27[1] | s27[0];
            Sz         <= sz_n;
            Ez_norm    <= ez9[EW-1:0];
            ovf_pre    <= ovf_n;
            denorm     <= den_n;
            zero       <= zero_n;
        end
    end

endmodule

// File: tb/tb_fpu_normalize.sv
// Directed, table-driven bench for fpu_normalize with hand-computed vectors
// plus streaming and mid-stream reset sequences.
module tb_fpu_normalize;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic [27:0] Mraw = '0;
    logic [7:0]  Ez_in = '0;
    logic        Sz_in = 1'b0;
    logic        eff_sub = 1'b0;
    logic [1:0]  R_mode_ext = 2'b00;
    logic        out_valid;
    logic [24:0] After_norm;
    logic        T;
    logic        Sz;
    logic [7:0]  Ez_norm;
    logic        ovf_pre;
    logic        denorm;
    logic        zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [27:0] mraw;
        logic [7:0]  ez;
        logic        sz;
        logic        sub;
        logic [1:0]  rm;
        logic [24:0] an;
        logic        t;
        logic        szo;
        logic [7:0]  ezo;
        logic        ovf;
        logic        den;
        logic        zr;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    fpu_normalize dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .Mraw(Mraw), .Ez_in(Ez_in),
        .Sz_in(Sz_in), .eff_sub(eff_sub), .R_mode_ext(R_mode_ext),
        .out_valid(out_valid), .After_norm(After_norm), .T(T), .Sz(Sz),
        .Ez_norm(Ez_norm), .ovf_pre(ovf_pre), .denorm(denorm), .zero(zero)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input logic vld);
        @(negedge CLK);
        in_valid   = vld;
        Mraw       = v.mraw;
        Ez_in      = v.ez;
        Sz_in      = v.sz;
        eff_sub    = v.sub;
        R_mode_ext = v.rm;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 0);
        checkOutput({tag, ".After_norm"}, 32'(After_norm), 0);
        checkOutput({tag, ".Ez_norm"}, 32'(Ez_norm), 0);
        checkOutput({tag, ".flags"}, {29'd0, ovf_pre, denorm, zero}, 0);
        checkOutput({tag, ".T_Sz"}, {30'd0, T, Sz}, 0);
    endtask

    initial begin
        vec_t v;
        //            mraw          ez    sz    sub   rm     an            t     szo   ezo   ovf   den   zr
        vecs[0]  = '{28'h8000000, 8'd127, 1'b0, 1'b0, 2'b00, 25'h1000000, 1'b0, 1'b0, 8'd128, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{28'h4000003, 8'd100, 1'b0, 1'b0, 2'b00, 25'h1000000, 1'b1, 1'b0, 8'd100, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{28'h0000100, 8'd100, 1'b0, 1'b1, 2'b00, 25'h1000000, 1'b0, 1'b0, 8'd82,  1'b0, 1'b0, 1'b0};
        vecs[3]  = '{28'h0000100, 8'd10,  1'b0, 1'b1, 2'b00, 25'h0008000, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        vecs[4]  = '{28'h0000000, 8'd50,  1'b0, 1'b1, 2'b11, 25'h0000000, 1'b0, 1'b1, 8'd0,   1'b0, 1'b0, 1'b1};
        vecs[5]  = '{28'h0000000, 8'd50,  1'b1, 1'b1, 2'b00, 25'h0000000, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1};
        vecs[6]  = '{28'h0000000, 8'd50,  1'b1, 1'b0, 2'b11, 25'h0000000, 1'b0, 1'b1, 8'd0,   1'b0, 1'b0, 1'b1};
        vecs[7]  = '{28'h8000000, 8'd254, 1'b0, 1'b0, 2'b00, 25'h1000000, 1'b0, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{28'h800000F, 8'd50,  1'b1, 1'b0, 2'b01, 25'h1000001, 1'b1, 1'b1, 8'd51,  1'b0, 1'b0, 1'b0};
        vecs[9]  = '{28'h0000100, 8'd0,   1'b0, 1'b0, 2'b00, 25'h0000040, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        vecs[10] = '{28'h0000100, 8'd18,  1'b0, 1'b1, 2'b00, 25'h0800000, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        vecs[11] = '{28'h0000100, 8'd19,  1'b1, 1'b1, 2'b10, 25'h1000000, 1'b0, 1'b1, 8'd1,   1'b0, 1'b0, 1'b0};
        vecs[12] = '{28'h0000001, 8'd200, 1'b0, 1'b1, 2'b00, 25'h1000000, 1'b0, 1'b0, 8'd174, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{28'h0000003, 8'd200, 1'b0, 1'b1, 2'b00, 25'h1800000, 1'b0, 1'b0, 8'd175, 1'b0, 1'b0, 1'b0};

        // Asynchronous reset with no clock edge needed
        #2 RST = 1'b0;
        #1 checkAllZero("reset");
        #20;
        @(negedge CLK) RST = 1'b1;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i], 1'b1);
            @(posedge CLK);
            @(posedge CLK);
            #1;
            checkOutput($sformatf("v%0d.out_valid", i), 32'(out_valid), 1);
            checkOutput($sformatf("v%0d.After_norm", i), 32'(After_norm), 32'(vecs[i].an));
            checkOutput($sformatf("v%0d.T", i), 32'(T), 32'(vecs[i].t));
            checkOutput($sformatf("v%0d.Sz", i), 32'(Sz), 32'(vecs[i].szo));
            checkOutput($sformatf("v%0d.Ez_norm", i), 32'(Ez_norm), 32'(vecs[i].ezo));
            checkOutput($sformatf("v%0d.ovf_pre", i), 32'(ovf_pre), 32'(vecs[i].ovf));
            checkOutput($sformatf("v%0d.denorm", i), 32'(denorm), 32'(vecs[i].den));
            checkOutput($sformatf("v%0d.zero", i), 32'(zero), 32'(vecs[i].zr));
        end

        // Drain, then stream 5 back-to-back beats tagged by exponent
        v = vecs[1];
        v.mraw = 28'h4000000;
        applyStimulus(v, 1'b0);
        repeat (2) @(posedge CLK);
        for (int k = 0; k < 7; k++) begin
            v.ez = 8'(10 + k);
            applyStimulus(v, (k < 5));
            @(posedge CLK);
            #1;
            if (k >= 1 && k <= 5) begin
                checkOutput($sformatf("stream%0d.out_valid", k), 32'(out_valid), 1);
                checkOutput($sformatf("stream%0d.Ez_norm", k), 32'(Ez_norm), 32'(10 + k - 1));
            end else begin
                checkOutput($sformatf("stream%0d.out_valid", k), 32'(out_valid), 0);
            end
        end

        // Two beats in flight when reset hits
        v = vecs[0];
        applyStimulus(v, 1'b1);
        @(posedge CLK);
        v.ez = 8'd20;
        applyStimulus(v, 1'b1);
        @(posedge CLK);
        #1 checkOutput("preRst.out_valid", 32'(out_valid), 1);
        #2;
        in_valid = 1'b0;
        RST = 1'b0;
        #1 checkAllZero("midRst");
        @(negedge CLK) RST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1 checkOutput($sformatf("postRst%0d.out_valid", k), 32'(out_valid), 0);
        end
        v = vecs[2];
        applyStimulus(v, 1'b1);
        @(posedge CLK);
        #1 checkOutput("relat1.out_valid", 32'(out_valid), 0);
        applyStimulus(v, 1'b0);
        @(posedge CLK);
        #1;
        checkOutput("relat2.out_valid", 32'(out_valid), 1);
        checkOutput("relat2.Ez_norm", 32'(Ez_norm), 82);
        @(posedge CLK);
        #1 checkOutput("relat3.out_valid", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
